window_filter_stream: RTL and testbench

WINDOW_FILTER_STREAM -- requirements
Module: window_filter_stream

---
 rtl/window_filter_pkg.sv | 17 +
 rtl/window_kernel.sv | 55 +++++
 rtl/window_filter_stream.sv | 150 +++++++++++++++
 tb/tb_window_filter_stream.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/window_filter_pkg.sv
// Shared types for the 3x3 window filter: mode encodings and stream state machine states.
package window_filter_pkg;

  typedef enum logic [1:0] {
    MODE_BLUR     = 2'b00,
    MODE_EDGE_TH  = 2'b01,
    MODE_EDGE_MAG = 2'b10,
    MODE_PASS     = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_FILL  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

endpackage

// File: rtl/window_kernel.sv
// Combinational 3x3 kernel: Gaussian blur, Sobel magnitude, thresholded Sobel or centre pass-through.
module window_kernel
  import window_filter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_win [9],
  input  mode_e             i_mode,
  input  logic [DATA_W-1:0] i_threshold,
  output logic [DATA_W-1:0] o_pixel
);

  localparam int SW = DATA_W + 4;

  logic        [SW-1:0]     w_a [9];
  logic        [SW-1:0]     w_sum;
  logic        [DATA_W-1:0] w_blur;
  logic signed [SW-1:0]     w_gx;
  logic signed [SW-1:0]     w_gy;
  logic signed [SW-1:0]     w_ax;
  logic signed [SW-1:0]     w_ay;
  logic        [SW-1:0]     w_mag;
  logic        [DATA_W-1:0] w_mag_sat;

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_ext
      assign w_a[gi] = SW'(i_win[gi]);
    end
  endgenerate

  assign w_sum  = w_a[0] + (w_a[1] << 1) + w_a[2]
                + (w_a[3] << 1) + (w_a[4] << 2) + (w_a[5] << 1)
                + w_a[6] + (w_a[7] << 1) + w_a[8];
  assign w_blur = DATA_W'(w_sum >> 4);

  assign w_gx = signed'((w_a[2] + (w_a[5] << 1) + w_a[8]) - (w_a[0] + (w_a[3] << 1) + w_a[6]));
  assign w_gy = signed'((w_a[6] + (w_a[7] << 1) + w_a[8]) - (w_a[0] + (w_a[1] << 1) + w_a[2]));
  assign w_ax = (w_gx < 0) ? -w_gx : w_gx;
  assign w_ay = (w_gy < 0) ? -w_gy : w_gy;
  assign w_mag = unsigned'(w_ax) + unsigned'(w_ay);
  // Anything above the pixel range clips to full scale.
  assign w_mag_sat = (w_mag[SW-1:DATA_W] != '0) ? '1 : w_mag[DATA_W-1:0];

  always_comb begin
    o_pixel = '0;
    case (i_mode)
      MODE_BLUR:     o_pixel = w_blur;
      MODE_EDGE_TH:  o_pixel = (w_mag_sat >= i_threshold) ? '1 : '0;
      MODE_EDGE_MAG: o_pixel = w_mag_sat;
      MODE_PASS:     o_pixel = i_win[4];
      default:       o_pixel = '0;
    endcase
  end

endmodule

// File: rtl/window_filter_stream.sv
// Streaming 3x3 window filter: two line buffers, sliding window, FILL/RUN/FLUSH control and a
// single registered output stage with valid/ready handshakes on both sides.
module window_filter_stream
  import window_filter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 850,
  parameter int IMG_H  = 850
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        select,
  input  logic [DATA_W-1:0] threshold,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_e            r_state, w_state_next;
  logic [CW-1:0]     r_in_col, r_out_col, w_in_col_next, w_rd_addr;
  logic [RW-1:0]     r_in_row, r_out_row;
  logic [DATA_W-1:0] r_lb0 [IMG_W];
  logic [DATA_W-1:0] r_lb1 [IMG_W];
  logic [DATA_W-1:0] r_lb0_q, r_lb1_q;
  logic [DATA_W-1:0] r_win [9];
  logic [DATA_W-1:0] w_win [9];
  mode_e             r_mode;
  logic [DATA_W-1:0] r_thr;
  logic              r_m_valid, r_last;
  logic [DATA_W-1:0] r_m_data, w_kernel;
  logic              w_out_free, w_ready, w_accept, w_produce, w_out_last, w_border;

  assign w_out_free = !r_m_valid || m_ready;
  assign w_out_last = (r_out_row == ROW_LAST) && (r_out_col == COL_LAST);

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_produce    = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_ready = w_out_free;
        // Input IMG_W (row 1, col 0) is the last one that produces no output.
        if (s_valid && w_ready && r_in_row == RW'(1) && r_in_col == '0)
          w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_ready   = w_out_free;
        w_produce = s_valid && w_ready;
        if (w_produce && r_in_row == ROW_LAST && r_in_col == COL_LAST)
          w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_produce = w_out_free;
        if (w_produce && w_out_last)
          w_state_next = ST_FILL;
      end
      default: w_state_next = ST_FILL;
    endcase
  end

  assign s_ready       = w_ready && !rst;
  assign w_accept      = s_valid && s_ready;
  assign w_in_col_next = (r_in_col == COL_LAST) ? '0 : r_in_col + 1'b1;
  // Read one column ahead so the registered read data matches the column of the next input.
  assign w_rd_addr     = w_accept ? w_in_col_next : r_in_col;

  always_ff @(posedge clk) begin
    r_lb0_q <= r_lb0[w_rd_addr];
    r_lb1_q <= r_lb1[w_rd_addr];
    if (w_accept) begin
      r_lb0[r_in_col] <= s_data;
      r_lb1[r_in_col] <= r_lb0_q;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_shift
      assign w_win[3*gi]   = r_win[3*gi+1];
      assign w_win[3*gi+1] = r_win[3*gi+2];
    end
  endgenerate
  assign w_win[2] = r_lb1_q;
  assign w_win[5] = r_lb0_q;
  assign w_win[8] = s_data;

  always_ff @(posedge clk) begin
    if (w_accept) r_win <= w_win;
  end

  window_kernel #(.DATA_W(DATA_W)) u_kernel (
    .i_win       (w_win),
    .i_mode      (r_mode),
    .i_threshold (r_thr),
    .o_pixel     (w_kernel)
  );

  assign w_border = (r_out_row == '0) || (r_out_row == ROW_LAST) ||
                    (r_out_col == '0) || (r_out_col == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FILL;
      r_in_col  <= '0;
      r_in_row  <= '0;
      r_out_col <= '0;
      r_out_row <= '0;
      r_mode    <= MODE_BLUR;
      r_thr     <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_last    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        if (r_state == ST_FILL && r_in_row == '0 && r_in_col == '0) begin
          r_mode <= mode_e'(select);
          r_thr  <= threshold;
        end
        r_in_col <= w_in_col_next;
        if (r_in_col == COL_LAST)
          r_in_row <= (r_in_row == ROW_LAST) ? '0 : r_in_row + 1'b1;
      end
      if (w_produce) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_border ? '0 : w_kernel;
        r_last    <= w_out_last;
        r_out_col <= (r_out_col == COL_LAST) ? '0 : r_out_col + 1'b1;
        if (r_out_col == COL_LAST)
          r_out_row <= (r_out_row == ROW_LAST) ? '0 : r_out_row + 1'b1;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_valid    = r_m_valid && !rst;
  assign m_data     = r_m_data;
  assign frame_done = m_valid && m_ready && r_last;

endmodule

// File: tb/tb_window_filter_stream.sv
// Randomised and directed bench for window_filter_stream on a 4x4 image, checked against a
// direct 2D arithmetic model of each filter mode.
module tb_window_filter_stream;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sel = 2'b00;
  logic [7:0] thr = 8'd0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'd0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       frame_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  window_filter_stream #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .select     (sel),
    .threshold  (thr),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .frame_done (frame_done)
  );

  function automatic int px(input int img[N], input int r, input int c);
    return img[r*W + c];
  endfunction

  function automatic int model(input int img[N], input int mode, input int th, input int pos);
    int r, c, gx, gy, mag;
    r = pos / W;
    c = pos % W;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
    if (mode == 3) return px(img, r, c);
    if (mode == 0) begin
      return (px(img,r-1,c-1) + 2*px(img,r-1,c) + px(img,r-1,c+1)
            + 2*px(img,r,c-1) + 4*px(img,r,c) + 2*px(img,r,c+1)
            + px(img,r+1,c-1) + 2*px(img,r+1,c) + px(img,r+1,c+1)) / 16;
    end
    gx = (px(img,r-1,c+1) + 2*px(img,r,c+1) + px(img,r+1,c+1))
       - (px(img,r-1,c-1) + 2*px(img,r,c-1) + px(img,r+1,c-1));
    gy = (px(img,r+1,c-1) + 2*px(img,r+1,c) + px(img,r+1,c+1))
       - (px(img,r-1,c-1) + 2*px(img,r-1,c) + px(img,r-1,c+1));
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > 255) mag = 255;
    if (mode == 2) return mag;
    return (mag >= th) ? 255 : 0;
  endfunction

  // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random. gap: random s_valid holes.
  task automatic run_frame(input string name, input int img[N], input int mode, input int th,
                           input int rdy_mode, input int gap, input int chg_at, input int chg_sel);
    int in_idx = 0;
    int out_idx = 0;
    int cyc = 0;
    int exp_v;
    bit hs;
    sel = 2'(mode);
    thr = 8'(th);
    while (out_idx < N && cyc < 2000) begin
      @(negedge clk);
      if (in_idx == chg_at) sel = 2'(chg_sel);
      s_valid = (in_idx < N) && (gap == 0 || $urandom_range(0, 2) != 0);
      if (in_idx < N) s_data = 8'(img[in_idx]);
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      #2;
      hs = m_valid && m_ready;
      if (s_valid && s_ready) in_idx++;
      vectors++;
      if (hs) begin
        exp_v = model(img, mode, th, out_idx);
        $display("%s out %0d data=%0d exp=%0d done=%0b", name, out_idx, m_data, exp_v, frame_done);
        if (m_data !== 8'(exp_v)) begin
          miscompares++;
          $display("FAIL %s data pos %0d: got %0d expected %0d", name, out_idx, m_data, exp_v);
        end
        if (frame_done !== (out_idx == N-1)) begin
          miscompares++;
          $display("FAIL %s frame_done pos %0d: got %0b expected %0b", name, out_idx, frame_done, out_idx == N-1);
        end
        out_idx++;
      end else if (frame_done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s frame_done without handshake: got %0b expected 0", name, frame_done);
      end
      cyc++;
    end
    vectors++;
    if (out_idx != N) begin
      miscompares++;
      $display("FAIL %s output count: got %0d expected %0d (cycle budget expired)", name, out_idx, N);
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      vectors++;
      if (m_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s extra output after frame: m_valid=%0b expected 0", name, m_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #2;
      vectors++;
      if (m_valid !== 1'b0 || s_ready !== 1'b0 || frame_done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset outputs: m_valid=%0b s_ready=%0b frame_done=%0b expected 0,0,0", m_valid, s_ready, frame_done);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    vectors++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL after reset: s_ready=%0b m_valid=%0b expected 1,0", s_ready, m_valid);
    end
  endtask

  task automatic test_blur_const();
    int img[N];
    for (int i = 0; i < N; i++) img[i] = 100;
    run_frame("blur_const", img, 0, 0, 0, 0, -1, 0);
  endtask

  task automatic test_edges();
    int img[N];
    for (int i = 0; i < N; i++) img[i] = (i % W >= 2) ? 200 : 0;
    run_frame("edge_th_step", img, 1, 100, 0, 0, -1, 0);
    run_frame("edge_mag_step", img, 2, 0, 0, 0, -1, 0);
    for (int i = 0; i < N; i++) img[i] = 100;
    run_frame("edge_mag_const", img, 2, 0, 0, 0, -1, 0);
  endtask

  task automatic test_pass_backpressure();
    int img[N];
    for (int i = 0; i < N; i++) img[i] = i;
    run_frame("pass_ramp", img, 3, 0, 1, 0, -1, 0);
  endtask

  task automatic test_reset_midframe();
    int img[N];
    int sent = 0;
    int cyc = 0;
    sel = 2'd0;
    m_ready = 1'b1;
    while (sent < 7 && cyc < 100) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = 8'($urandom_range(0, 255));
      #2;
      if (s_ready) sent++;
      cyc++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    #2;
    vectors++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe reset cycle: m_valid=%0b s_ready=%0b expected 0,0", m_valid, s_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) img[i] = 50;
    run_frame("after_reset_const50", img, 0, 0, 0, 0, -1, 0);
  endtask

  task automatic test_select_midframe();
    int img[N];
    for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
    run_frame("select_change", img, 0, 0, 2, 1, 8, 3);
    for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
    run_frame("select_next", img, 3, 0, 2, 1, -1, 0);
  endtask

  task automatic test_random();
    int img[N];
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
      run_frame("random", img, $urandom_range(0, 3), $urandom_range(0, 255), 2, 1, -1, 0);
    end
  endtask

  task automatic test_back_to_back();
    int img[N];
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
      run_frame("back_to_back", img, f == 0 ? 1 : 2, $urandom_range(0, 255), 0, 0, -1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_blur_const();
    test_edges();
    test_pass_backpressure();
    test_reset_midframe();
    test_select_midframe();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
